// File: rtl/alarm_responder.sv
// Alarm consumer: synchronise/debounce the detector alarm, drive siren and lamp until
// acknowledged, escalate on timeout. Optional ALARM_RESP_AUTOREARM_EN re-arms from ACKED.
module alarm_responder #(
  parameter int DEBOUNCE    = 4,
  parameter int BLINK_HALF  = 8,
  parameter int ESC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alarm_in,
  input  logic       ack,
  input  logic       clear,
  output logic       siren,
  output logic       lamp,
  output logic       escalate,
  output logic [7:0] event_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMING = 3'd1,
    S_ALERT  = 3'd2,
    S_ESC    = 3'd3,
    S_ACKED  = 3'd4
  } state_t;

  localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);
  localparam logic [15:0] ESC_LAST   = 16'(ESC_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic [15:0] esc_cnt_q, esc_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  event_count_q, event_count_d;
  logic        alarm_s;
`ifdef ALARM_RESP_AUTOREARM_EN
  logic [7:0]  rearm_cnt_q, rearm_cnt_d;
`endif

  assign alarm_s = sync_q[1];

  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[0], alarm_in};
    deb_cnt_d     = deb_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    esc_cnt_d     = esc_cnt_q;
    phase_d       = phase_q;
    event_count_d = event_count_q;
`ifdef ALARM_RESP_AUTOREARM_EN
    rearm_cnt_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (alarm_s) begin
          state_d   = S_ARMING;
          deb_cnt_d = 8'd1;
        end
      end
      S_ARMING: begin
        if (!alarm_s) begin
          state_d   = S_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = S_ALERT;
          deb_cnt_d   = '0;
          esc_cnt_d   = '0;
          blink_cnt_d = '0;
          phase_d     = 1'b1;
          if (event_count_q != 8'hff) event_count_d = event_count_q + 8'd1;
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      S_ALERT: begin
        esc_cnt_d = esc_cnt_q + 16'd1;
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
        // ack outranks the timeout when both land on the same cycle
        if (ack)                        state_d = S_ACKED;
        else if (esc_cnt_q == ESC_LAST) state_d = S_ESC;
      end
      S_ESC: begin
        if (ack) state_d = S_ACKED;
      end
      S_ACKED: begin
`ifdef ALARM_RESP_AUTOREARM_EN
        // consecutive quiet cycles; DEBOUNCE of them re-arms without clear
        if (!alarm_s) begin
          rearm_cnt_d = rearm_cnt_q + 8'd1;
          if (rearm_cnt_q == DEB_LAST) state_d = S_IDLE;
        end
`endif
        if (clear && !alarm_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sync_q        <= '0;
      deb_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      esc_cnt_q     <= '0;
      phase_q       <= 1'b0;
      event_count_q <= '0;
`ifdef ALARM_RESP_AUTOREARM_EN
      rearm_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      deb_cnt_q     <= deb_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      esc_cnt_q     <= esc_cnt_d;
      phase_q       <= phase_d;
      event_count_q <= event_count_d;
`ifdef ALARM_RESP_AUTOREARM_EN
      rearm_cnt_q   <= rearm_cnt_d;
`endif
    end
  end

  assign siren       = (state_q == S_ALERT) ? phase_q : (state_q == S_ESC);
  assign lamp        = (state_q == S_ALERT) || (state_q == S_ESC) || (state_q == S_ACKED);
  assign escalate    = (state_q == S_ESC);
  assign event_count = event_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Bench for alarm_responder: vector table, directed corner sequences, then random
// stimulus against a cycle-count based reference model.
module tb_alarm_responder;
  localparam int DEB = 4;
  localparam int BH  = 8;
  localparam int ET  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alarm_in = 1'b0, ack = 1'b0, clear = 1'b0;
  logic       siren, lamp, escalate;
  logic [7:0] event_count;
  logic [2:0] state;

  int pass_cnt = 0;
  int total_cnt = 0;

  alarm_responder #(.DEBOUNCE(DEB), .BLINK_HALF(BH), .ESC_TIMEOUT(ET)) dut (
    .clk(clk), .rst_n(rst_n), .alarm_in(alarm_in), .ack(ack), .clear(clear),
    .siren(siren), .lamp(lamp), .escalate(escalate),
    .event_count(event_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic a, k, c;
    int   st;
    logic sir, lmp, esc;
    int   cnt;
  } vec_t;
  vec_t tbl[17];

  // reference model: state as small int, alert age in cycles, run lengths
  int m_st, m_run, m_t, m_cnt, m_low;
  bit m_s1, m_s2;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic a, input logic k, input logic c);
    alarm_in = a; ack = k; clear = c;
  endtask

  task automatic qualify(output bit ok);
    ok = 0;
    set_in(1, 0, 0);
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (state == 3'd2) ok = 1;
    end
    chk("qualify_reached_alert", int'(ok), 1);
  endtask

  task automatic ack_and_clear();
    set_in(1, 1, 0); step();
    set_in(0, 0, 0); step(); step(); step();
    set_in(0, 0, 1); step();
    set_in(0, 0, 0);
  endtask

  task automatic model_reset();
    m_st = 0; m_run = 0; m_t = 0; m_cnt = 0; m_low = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step();
    bit s;
    s = m_s2;
    case (m_st)
      0: if (s) begin m_st = 1; m_run = 1; end
      1: if (!s) m_st = 0;
         else if (m_run == DEB - 1) begin
           m_st = 2; m_t = 0; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         end else m_run++;
      2: if (ack) begin m_st = 4; m_low = 0; end
         else if (m_t == ET - 1) m_st = 3;
         else m_t++;
      3: if (ack) begin m_st = 4; m_low = 0; end
      4: begin
`ifdef ALARM_RESP_AUTOREARM_EN
           if (s) m_low = 0;
           else begin
             m_low++;
             if (m_low == DEB) m_st = 0;
           end
`endif
           if (clear && !s) m_st = 0;
         end
      default: m_st = 0;
    endcase
    m_s2 = m_s1;
    m_s1 = alarm_in;
  endtask

  initial begin
    bit ok;
    int exp_sir;

    tbl[0]  = '{1,0,0, 0,0,0,0, 0};
    tbl[1]  = '{1,0,0, 0,0,0,0, 0};
    tbl[2]  = '{1,0,0, 1,0,0,0, 0};
    tbl[3]  = '{1,0,0, 1,0,0,0, 0};
    tbl[4]  = '{1,0,0, 1,0,0,0, 0};
    tbl[5]  = '{1,0,0, 2,1,1,0, 1};
    tbl[6]  = '{1,1,0, 4,0,1,0, 1};
    tbl[7]  = '{1,0,1, 4,0,1,0, 1};
    tbl[8]  = '{0,0,0, 4,0,1,0, 1};
    tbl[9]  = '{0,0,0, 4,0,1,0, 1};
    tbl[10] = '{0,0,1, 0,0,0,0, 1};
    tbl[11] = '{1,0,0, 0,0,0,0, 1};
    tbl[12] = '{1,0,0, 0,0,0,0, 1};
    tbl[13] = '{0,0,0, 1,0,0,0, 1};
    tbl[14] = '{0,0,0, 1,0,0,0, 1};
    tbl[15] = '{0,0,0, 0,0,0,0, 1};
    tbl[16] = '{0,0,0, 0,0,0,0, 1};

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_state", state, 0);
      chk("rst_outs", {siren, lamp, escalate}, 0);
      chk("rst_count", event_count, 0);
    end
    rst_n = 1'b1;

    // qualification, ack, clear gating, glitch rejection
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].a, tbl[i].k, tbl[i].c);
      step();
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_siren", i), siren, tbl[i].sir);
      chk($sformatf("vec%0d_lamp", i), lamp, tbl[i].lmp);
      chk($sformatf("vec%0d_esc", i), escalate, tbl[i].esc);
      chk($sformatf("vec%0d_count", i), event_count, tbl[i].cnt);
    end

    // blink and escalation with alarm held, no ack
    qualify(ok);
    for (int k = 1; k <= 70; k++) begin
      step();
      exp_sir = (k < ET) ? (((k / BH) % 2) == 0) : 1;
      chk("blink_state", state, (k < ET) ? 2 : 3);
      chk("blink_siren", siren, exp_sir);
      chk("blink_escalate", escalate, (k < ET) ? 0 : 1);
    end
    ack_and_clear();
    chk("esc_clear_state", state, 0);
    chk("esc_clear_lamp", lamp, 0);

    // ack lands in the same cycle as the timeout
    qualify(ok);
    for (int k = 1; k < ET; k++) begin
      step();
      chk("race_no_escalate", escalate, 0);
    end
    set_in(1, 1, 0); step();
    chk("race_state", state, 4);
    chk("race_escalate", escalate, 0);
    chk("race_siren", siren, 0);
    chk("race_lamp", lamp, 1);
    set_in(0, 0, 0); step(); step(); step();
    set_in(0, 0, 1); step();
    set_in(0, 0, 0);
    chk("race_clear_state", state, 0);
    chk("race_count", event_count, 3);

    // saturation of event_count
    for (int i = 0; i < 260; i++) begin
      qualify(ok);
      ack_and_clear();
    end
    chk("sat_count", event_count, 255);

    // async reset mid-ALERT, between edges
    qualify(ok);
    for (int i = 0; i < 5; i++) step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_outs", {siren, lamp, escalate}, 0);
    chk("async_rst_count", event_count, 0);
    set_in(0, 0, 0);
    step(); step();
    rst_n = 1'b1;

    // randomized run against the reference model
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) alarm_in = ~alarm_in;
      ack   = ($urandom_range(0, 79) == 0);
      clear = ($urandom_range(0, 3) == 0);
      model_step();
      step();
      exp_sir = (m_st == 2) ? (((m_t / BH) % 2) == 0) : (m_st == 3);
      chk("rnd_state", state, m_st);
      chk("rnd_siren", siren, exp_sir);
      chk("rnd_lamp", lamp, (m_st >= 2) ? 1 : 0);
      chk("rnd_escalate", escalate, (m_st == 3) ? 1 : 0);
      chk("rnd_count", event_count, m_cnt);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alarm_responder.md
# alarm_responder

Consumer-side controller for the accident alarm output. Takes the raw alarm level from the combinational accident detector, synchronises and debounces it, then drives a pulsing siren and a warning lamp until an operator acknowledges. Escalates to an emergency line if no acknowledge arrives in time, and keeps a saturating count of qualified alarm events.

## Interface
- `DEBOUNCE`, default 4: consecutive synchronised-high cycles needed to qualify an alarm; legal range is 2 to 255.
- `BLINK_HALF`, default 8: siren half-period in cycles while in ALERT; must be 1 or more.
- `ESC_TIMEOUT`, default 64: cycles spent in ALERT without an acknowledge before escalation; legal range is 1 to 65535.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alarm_in`  in  1  raw detector alarm level, asynchronous to `clk`.
- `ack`  in  1  operator acknowledge, level sampled each cycle.
- `clear`  in  1  operator clear, level sampled each cycle.
- `siren`  out  1  siren drive.
- `lamp`  out  1  warning lamp.
- `escalate`  out  1  emergency line request.
- `event_count`  out  8  number of qualified alarms, saturating.
- `state`  out  3  current state code.

## Operation
- `alarm_in` passes through a 2-flop synchroniser; its output is `alarm_s`. Only `alarm_s` is used internally.
- State codes: IDLE=0, ARMING=1, ALERT=2, ESCALATED=3, ACKED=4.
- **IDLE**
  - `alarm_s`=1 moves to ARMING with `deb_cnt`=1.
- **ARMING**
  - `alarm_s`=0 returns to IDLE and sets `deb_cnt`=0.
  - Otherwise `deb_cnt` increments.
  - When `deb_cnt`==DEBOUNCE-1 and `alarm_s`=1, move to ALERT and increment `event_count`. `event_count` saturates at 255.
- **ALERT**
  - On entry: `esc_cnt`=0, `blink_cnt`=0, siren phase=1.
  - `esc_cnt` increments every cycle.
  - `blink_cnt` wraps at BLINK_HALF-1; the siren phase toggles on each wrap.
  - `ack`=1 moves to ACKED.
  - When `esc_cnt`==ESC_TIMEOUT-1, move to ESCALATED.
- **ESCALATED**
  - `ack`=1 moves to ACKED.
- **ACKED**
  - `clear`=1 and `alarm_s`=0 together move to IDLE.
  - `clear` while `alarm_s`=1 is ignored.
- Outputs, all Moore, decoded from registered state:
  - `siren` = blink phase in ALERT, 1 in ESCALATED, otherwise 0.
  - `lamp` = 1 in ALERT, ESCALATED and ACKED.
  - `escalate` = 1 only in ESCALATED.
- `alarm_s` falling while in ALERT or ESCALATED does not leave the state. An alarm persists until acknowledged.
- Ignored inputs:
  - `ack` in IDLE, ARMING and ACKED.
  - `clear` in any state other than ACKED.
- Counter widths: `deb_cnt` 8 bits, `blink_cnt` 16 bits, `esc_cnt` 16 bits.

## Timing
- Reset values:
  - state IDLE.
  - `siren`=0, `lamp`=0, `escalate`=0, `event_count`=0.
  - All internal counters and synchroniser flops 0.
- Reset is asynchronous to `clk` and takes effect immediately, including mid-ALERT or mid-ESCALATED.
- Alarm qualification latency: with `alarm_in` high from before edge N, `alarm_s`=1 after edge N+1 and ARMING is entered after edge N+2. ALERT is entered after edge N+1+DEBOUNCE, which is N+5 at the default DEBOUNCE=4.
- A one-cycle `alarm_s` glitch reaches ARMING but never ALERT.
- Simultaneous events:
  - `ack` and escalation timeout in the same cycle: `ack` wins and the next state is ACKED.
  - `ack` and a blink wrap in the same cycle: the next state is ACKED, so `siren`=0.
- Escalation occurs ESC_TIMEOUT cycles after ALERT entry.
- `ack`-to-outputs latency is one cycle: `siren`, `escalate`, and `state` update on the next edge.

## Configuration
- Macro: `ALARM_RESP_AUTOREARM_EN`.
- **Defined:** in ACKED, a second counter counts consecutive `alarm_s`=0 cycles and resets on `alarm_s`=1. Reaching DEBOUNCE returns the block to IDLE without `clear`. `clear` still works as in the undefined case.
- **Undefined:** ACKED exits only via `clear`=1 with `alarm_s`=0; the counter logic is absent.

## Test plan
- **Reset and qualification:** hold `rst_n`=0 for 3 cycles, then raise `alarm_in` before edge 10 -> all outputs 0 during reset; `state`=2, `siren`=1, `lamp`=1 and `event_count`=1 after edge 15.
- **Glitch rejection:** `alarm_in` high for 2 cycles then low -> `state` visits 1 and returns to 0; `siren` stays 0; `event_count` stays 0.
- **Blink and escalation:** hold the alarm with no `ack` -> `siren` toggles every 8 cycles; at 64 cycles after ALERT entry, `state`=3, `escalate`=1, `siren`=1 steady.
- **Ack-vs-timeout race:** assert `ack` in the cycle where `esc_cnt`=63 -> `state`=4, `escalate` never rises, `siren`=0, `lamp`=1.
- **Clear gating:** in ACKED, `clear`=1 while `alarm_in`=1 -> `state` stays 4; drop `alarm_in`, wait 2 cycles, then `clear`=1 -> `state`=0 and `lamp`=0.
- **Saturation and async reset:** qualify 260 alarms -> `event_count`=255; pulse `rst_n` low mid-ALERT between clock edges -> outputs 0 immediately.
